// File: rtl/range_pkg.sv
// range_pkg: shared state/error encodings and per-width extreme constants for the range tracker.
package range_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
    typedef enum logic [1:0] {E_NONE, E_FINISH_NO_GO, E_EMPTY, E_COUNT_SAT} err_code_t;

    function automatic logic [63:0] type_max(input int w, input bit s);
        return s ? (64'd1 << (w - 1)) - 64'd1 : (w >= 64 ? '1 : (64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] type_min(input int w, input bit s);
        return s ? 64'd1 << (w - 1) : 64'd0;
    endfunction
endpackage

// File: rtl/range_lane.sv
// range_lane: running min/max of one sample lane; exposes next values so a finish-cycle sample is latched too.
module range_lane
    import range_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] next_min,
    output logic [WIDTH-1:0] next_max
);
    localparam logic [WIDTH-1:0] TMAX = WIDTH'(type_max(WIDTH, SIGNED));
    localparam logic [WIDTH-1:0] TMIN = WIDTH'(type_min(WIDTH, SIGNED));

    logic [WIDTH-1:0] cur_min, cur_max;
    logic below, above;

    always_comb begin
        below    = SIGNED ? ($signed(data) < $signed(cur_min)) : (data < cur_min);
        above    = SIGNED ? ($signed(data) > $signed(cur_max)) : (data > cur_max);
        next_min = (sample_en && below) ? data : cur_min;
        next_max = (sample_en && above) ? data : cur_max;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset || clear) begin
            cur_min <= TMAX;
            cur_max <= TMIN;
        end else begin
            cur_min <= next_min;
            cur_max <= next_max;
        end
    end
endmodule

// File: rtl/range_tracker_multi.sv
// range_tracker_multi: NCH parallel min/max/range trackers under one go/finish session,
// with saturating sample count, latched results, done strobe and coded errors.
module range_tracker_multi
    import range_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NCH    = 4,
    parameter int CNTW   = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic                 finish,
    input  logic                 data_valid,
    input  logic [NCH*WIDTH-1:0] data_in,
    output logic [NCH*WIDTH-1:0] min_out,
    output logic [NCH*WIDTH-1:0] max_out,
    output logic [NCH*WIDTH-1:0] range_out,
    output logic [CNTW-1:0]      sample_count,
    output logic                 done,
    output logic                 busy,
    output logic                 error,
    output logic [1:0]           error_code
);
    state_t                 state;
    err_code_t              code;
    logic [CNTW-1:0]        count, next_count;
    logic [NCH*WIDTH-1:0]   nmin, nmax, nrng;
    logic                   accept, start, empty;

    assign accept     = data_valid && state == RUN;
    assign start      = go && (state == ERR || state == DONE || (state == IDLE && !finish));
    assign next_count = (accept && count != '1) ? count + CNTW'(1) : count;
    assign empty      = next_count == '0;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        range_lane #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_lane (
            .clock    (clock),
            .reset    (reset),
            .clear    (start),
            .sample_en(accept),
            .data     (data_in[i*WIDTH +: WIDTH]),
            .next_min (nmin[i*WIDTH +: WIDTH]),
            .next_max (nmax[i*WIDTH +: WIDTH])
        );
        assign nrng[i*WIDTH +: WIDTH] = nmax[i*WIDTH +: WIDTH] - nmin[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            code         <= E_NONE;
            count        <= '0;
            min_out      <= '0;
            max_out      <= '0;
            range_out    <= '0;
            sample_count <= '0;
        end else if (start) begin
            state <= RUN;
            code  <= E_NONE;
            count <= '0;
        end else begin
            case (state)
                IDLE: if (finish) begin
                    state <= ERR;
                    code  <= E_FINISH_NO_GO;
                end
                RUN: begin
                    count <= next_count;
                    if (accept && count == '1) code <= E_COUNT_SAT;
                    // Finish-cycle sample is already folded into next_* values.
                    if (finish) begin
                        state        <= empty ? ERR : DONE;
                        min_out      <= empty ? '0 : nmin;
                        max_out      <= empty ? '0 : nmax;
                        range_out    <= empty ? '0 : nrng;
                        sample_count <= next_count;
                        if (empty) code <= E_EMPTY;
                    end
                end
                DONE: state <= IDLE;
                default: ;
            endcase
        end
    end

    assign done       = state == DONE;
    assign busy       = state == RUN;
    assign error      = state == ERR;
    assign error_code = code;
endmodule
